// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_RD   = 2;
    localparam int ZERO_IDX     = 0;

    // Address width for a power-of-two register count (minimum 2 registers).
    function automatic int addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on a collision.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 0,
    parameter int AW       = addr_w(DEF_NUM_REGS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so a newer producer stays pending.
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[ZERO_IDX] = 1'b0;
        end
        if (RESET) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with optional zero register, write-through bypass
// and a RAW-hazard scoreboard.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WRITE,
    input  logic [AW-1:0]            INADDRESS,
    input  logic [DATA_W-1:0]        IN,
    input  logic [NUM_RD*AW-1:0]     RDADDR,
    output logic [NUM_RD*DATA_W-1:0] RDDATA,
    output logic [NUM_RD-1:0]        RDBUSY,
    input  logic                     ISSUE,
    input  logic [AW-1:0]            ISSUEADDR,
    output logic [NUM_REGS-1:0]      BUSYVEC
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (INADDRESS == AW'(ZERO_IDX));

    always_comb begin
        regs_d = regs_q;
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (WRITE && !wr_zero) begin
            regs_d[INADDRESS] = IN;
        end
    end

    always_ff @(posedge CLK) begin
        regs_q <= regs_d;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .CLK      (CLK),
        .RESET    (RESET),
        .clr_en   (WRITE),
        .clr_addr (INADDRESS),
        .set_en   (ISSUE),
        .set_addr (ISSUEADDR),
        .busy_vec (BUSYVEC)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] raddr;
        logic          is_zero;
        logic          fwd;

        assign raddr   = RDADDR[k*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (raddr == AW'(ZERO_IDX));
        // A forwarded write also resolves the hazard it would have reported.
        assign fwd     = (BYPASS != 0) && WRITE && (INADDRESS == raddr) && !is_zero;

        assign RDDATA[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                            fwd     ? IN : regs_q[raddr];
        assign RDBUSY[k] = !is_zero && !fwd && BUSYVEC[raddr];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised scoreboard bench for reg_file_sb across three bypass/zero-register configurations.
module tb_reg_file_sb;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       WRITE = 1'b0;
    logic [2:0] INADDRESS = '0;
    logic [7:0] IN = '0;
    logic [5:0] RDADDR = '0;
    logic       ISSUE = 1'b0;
    logic [2:0] ISSUEADDR = '0;

    logic [15:0] rd_a, rd_b, rd_c;
    logic [1:0]  rb_a, rb_b, rb_c;
    logic [7:0]  bv_a, bv_b, bv_c;

    always #5 CLK = ~CLK;

    reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) u_a (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .RDADDR(RDADDR), .RDDATA(rd_a), .RDBUSY(rb_a), .ISSUE(ISSUE),
        .ISSUEADDR(ISSUEADDR), .BUSYVEC(bv_a));

    reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .RDADDR(RDADDR), .RDDATA(rd_b), .RDBUSY(rb_b), .ISSUE(ISSUE),
        .ISSUEADDR(ISSUEADDR), .BUSYVEC(bv_b));

    reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_c (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .RDADDR(RDADDR), .RDDATA(rd_c), .RDBUSY(rb_c), .ISSUE(ISSUE),
        .ISSUEADDR(ISSUEADDR), .BUSYVEC(bv_c));

    // Reference model: one register array and busy array per configuration.
    int unsigned mem [3][8];
    bit          bsy [3][8];
    bit          cfg_byp  [3] = '{1'b1, 1'b0, 1'b1};
    bit          cfg_zero [3] = '{1'b0, 1'b0, 1'b1};

    typedef struct packed {
        logic [47:0] rd;
        logic [5:0]  rb;
        logic [23:0] bv;
    } exp_t;

    exp_t exp_q [$];
    event push_ev;
    int   checks = 0;
    int   errors = 0;

    function automatic bit fwd_hit(int c, int addr);
        return cfg_byp[c] && WRITE && (int'(INADDRESS) == addr);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e = '0;
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 2; p++) begin
                int a;
                a = int'(RDADDR[p*3 +: 3]);
                if (cfg_zero[c] && a == 0) begin
                    e.rd[c*16 + p*8 +: 8] = 8'h00;
                    e.rb[c*2 + p]         = 1'b0;
                end else if (fwd_hit(c, a)) begin
                    e.rd[c*16 + p*8 +: 8] = IN;
                    e.rb[c*2 + p]         = 1'b0;
                end else begin
                    e.rd[c*16 + p*8 +: 8] = mem[c][a][7:0];
                    e.rb[c*2 + p]         = bsy[c][a];
                end
            end
            for (int r = 0; r < 8; r++) begin
                e.bv[c*8 + r] = bsy[c][r];
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            if (RESET) begin
                for (int r = 0; r < 8; r++) begin
                    mem[c][r] = 0;
                    bsy[c][r] = 1'b0;
                end
            end else begin
                if (WRITE && !(cfg_zero[c] && INADDRESS == 3'd0)) begin
                    mem[c][INADDRESS] = IN;
                    bsy[c][INADDRESS] = 1'b0;
                end
                if (ISSUE && !(cfg_zero[c] && ISSUEADDR == 3'd0)) begin
                    bsy[c][ISSUEADDR] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit wr, input int wa, input int wd,
                        input int ra0, input int ra1, input bit is, input int ia);
        @(negedge CLK);
        RESET     = rst;
        WRITE     = wr;
        INADDRESS = 3'(wa);
        IN        = 8'(wd);
        RDADDR    = {3'(ra1), 3'(ra0)};
        ISSUE     = is;
        ISSUEADDR = 3'(ia);
        #1;
        exp_q.push_back(predict());
        -> push_ev;
        @(posedge CLK);
        model_edge();
    endtask

    task automatic idle_read(input int ra0, input int ra1);
        step(1'b0, 1'b0, 0, 0, ra0, ra1, 1'b0, 0);
    endtask

    // Monitor: compares every presented output set against the oldest prediction.
    initial begin
        exp_t e;
        logic [47:0] act_rd;
        logic [5:0]  act_rb;
        logic [23:0] act_bv;
        forever begin
            @(push_ev);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act_rd = {rd_c, rd_b, rd_a};
                act_rb = {rb_c, rb_b, rb_a};
                act_bv = {bv_c, bv_b, bv_a};
                for (int c = 0; c < 3; c++) begin
                    checks++;
                    if (act_rd[c*16 +: 16] !== e.rd[c*16 +: 16]) begin
                        errors++;
                        $display("FAIL rddata_cfg%0d t=%0t got %h want %h", c, $time,
                                 act_rd[c*16 +: 16], e.rd[c*16 +: 16]);
                    end
                    checks++;
                    if (act_rb[c*2 +: 2] !== e.rb[c*2 +: 2]) begin
                        errors++;
                        $display("FAIL rdbusy_cfg%0d t=%0t got %b want %b", c, $time,
                                 act_rb[c*2 +: 2], e.rb[c*2 +: 2]);
                    end
                    checks++;
                    if (act_bv[c*8 +: 8] !== e.bv[c*8 +: 8]) begin
                        errors++;
                        $display("FAIL busyvec_cfg%0d t=%0t got %b want %b", c, $time,
                                 act_bv[c*8 +: 8], e.bv[c*8 +: 8]);
                    end
                end
            end
        end
    end

    initial begin
        // Initial reset establishes known state before any prediction is made.
        RESET = 1'b1;
        @(posedge CLK);
        model_edge();
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);

        // Random writes/issues, then reset and read back every address.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, $urandom_range(7), $urandom_range(255),
                 $urandom_range(7), $urandom_range(7), 1'b1, $urandom_range(7));
        end
        step(1'b1, 1'b1, 2, 8'hEE, 2, 2, 1'b1, 3);
        for (int a = 0; a < 8; a++) idle_read(a, a);

        // Write then read on both ports.
        step(1'b0, 1'b1, 3, 8'h5A, 0, 0, 1'b0, 0);
        idle_read(3, 3);

        // Same-cycle bypass, then the registered value.
        step(1'b0, 1'b1, 4, 8'h11, 0, 0, 1'b0, 0);
        step(1'b0, 1'b1, 4, 8'h22, 4, 1, 1'b0, 0);
        idle_read(4, 4);

        // Scoreboard set by issue, cleared by writeback.
        step(1'b0, 1'b0, 0, 0, 5, 5, 1'b1, 5);
        idle_read(5, 5);
        step(1'b0, 1'b1, 5, 8'h7F, 5, 5, 1'b0, 0);
        idle_read(5, 5);

        // Collision on one address: data written, busy stays set.
        step(1'b0, 1'b0, 0, 0, 2, 2, 1'b1, 2);
        step(1'b0, 1'b1, 2, 8'h33, 2, 2, 1'b1, 2);
        idle_read(2, 2);
        // Different addresses: both take effect.
        step(1'b0, 1'b1, 2, 8'h44, 2, 6, 1'b1, 6);
        idle_read(2, 6);

        // Writes and issues to register 0.
        step(1'b0, 1'b1, 0, 8'hFF, 0, 0, 1'b1, 0);
        idle_read(0, 0);
        step(1'b0, 1'b1, 0, 8'hA5, 0, 0, 1'b0, 0);
        idle_read(0, 0);

        // Mid-operation reset discards pending producers.
        step(1'b0, 1'b0, 0, 0, 1, 7, 1'b1, 7);
        step(1'b1, 1'b0, 0, 0, 7, 2, 1'b0, 0);
        idle_read(7, 2);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 2), $urandom_range(1), $urandom_range(7),
                 $urandom_range(255), $urandom_range(7), $urandom_range(7),
                 $urandom_range(1), $urandom_range(7));
        end

        RESET = 1'b0;
        WRITE = 1'b0;
        ISSUE = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
